// File: rtl/m_cache_assoc.sv
// Set-associative, write-through-style data cache (write-noallocate) with a
// blocking single-line refill port and a one-set-per-cycle flush engine.
module m_cache_assoc #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 8,
  parameter int WAYS        = 2,
  parameter int WORDS       = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [31:0]           o_rsp_data,
  output logic                  o_rsp_hit,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_rsp_valid,
  input  logic [32*WORDS-1:0]   i_mem_rsp_data,
  input  logic                  i_flush,
  output logic                  o_busy
);

  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int OFF_W     = $clog2(WORDS);
  localparam int OFF_SEL_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int LINE_LSB  = OFF_W + 2;
  localparam int TAG_LSB   = LINE_LSB + INDEX_WIDTH;
  localparam int TAG_W     = ADDR_WIDTH - TAG_LSB;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, FLUSH
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   req_we;
  logic [31:0]            req_wdata;
  logic [32*WORDS-1:0]    line_buf;
  logic [INDEX_WIDTH-1:0] flush_idx;

  logic [SETS-1:0]  valid_q  [WAYS];
  logic [WAY_W-1:0] rr_ptr   [SETS];
  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
  logic [31:0]      data_mem [WAYS][SETS][WORDS];

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [OFF_SEL_W-1:0]   req_off;
  logic                   unused_addr_bits;

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             all_valid;
  logic [WAY_W-1:0] rr_next;

  assign req_idx          = req_addr[TAG_LSB-1:LINE_LSB];
  assign req_tag          = req_addr[ADDR_WIDTH-1:TAG_LSB];
  assign unused_addr_bits = ^req_addr[1:0];

  generate
    if (OFF_W > 0) begin : g_off
      assign req_off = req_addr[LINE_LSB-1:2];
    end else begin : g_no_off
      assign req_off = '0;
    end
  endgenerate

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Walk downwards so the lowest-numbered invalid way is the one left standing.
  always_comb begin
    victim    = rr_ptr[req_idx];
    all_valid = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        victim    = WAY_W'(w);
        all_valid = 1'b0;
      end
    end
    if (int'(rr_ptr[req_idx]) == WAYS - 1) rr_next = '0;
    else                                    rr_next = rr_ptr[req_idx] + 1'b1;
  end

  always_comb begin
    state_next  = state;
    o_rsp_valid = 1'b0;
    o_rsp_hit   = 1'b0;
    o_rsp_data  = '0;
    case (state)
      IDLE: begin
        if (i_flush)          state_next = FLUSH;
        else if (i_req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit_any) begin
          o_rsp_valid = 1'b1;
          o_rsp_hit   = 1'b1;
          o_rsp_data  = req_we ? 32'h0 : data_mem[hit_way][req_idx][req_off];
          state_next  = IDLE;
        end else if (req_we) begin
          o_rsp_valid = 1'b1;
          state_next  = IDLE;
        end else begin
          state_next = MISS_REQ;
        end
      end
      MISS_REQ:  if (i_mem_req_ready) state_next = MISS_WAIT;
      MISS_WAIT: if (i_mem_rsp_valid) state_next = FILL;
      FILL: begin
        o_rsp_valid = 1'b1;
        o_rsp_data  = line_buf[int'(req_off)*32 +: 32];
        state_next  = IDLE;
      end
      FLUSH: if (flush_idx == INDEX_WIDTH'(SETS - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign o_req_ready     = (state == IDLE) && !i_flush;
  assign o_busy          = (state != IDLE);
  assign o_mem_req_valid = (state == MISS_REQ);
  assign o_mem_addr      = (state == MISS_REQ) ?
                           {req_addr[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}} : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      flush_idx <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && i_flush) flush_idx <= '0;
      if (state == FLUSH) begin
        for (int w = 0; w < WAYS; w++) valid_q[w][flush_idx] <= 1'b0;
        flush_idx <= flush_idx + 1'b1;
      end
      // The pointer only advances when a fill actually displaces a valid line.
      if (state == FILL) begin
        valid_q[victim][req_idx] <= 1'b1;
        if (all_valid) rr_ptr[req_idx] <= rr_next;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == IDLE && !i_flush && i_req_valid) begin
      req_addr  <= i_req_addr;
      req_we    <= i_req_we;
      req_wdata <= i_req_wdata;
    end
    if (state == MISS_WAIT && i_mem_rsp_valid) line_buf <= i_mem_rsp_data;
    if (state == LOOKUP && hit_any && req_we)
      data_mem[hit_way][req_idx][req_off] <= req_wdata;
    if (state == FILL) begin
      tag_mem[victim][req_idx] <= req_tag;
      for (int w = 0; w < WORDS; w++)
        data_mem[victim][req_idx][w] <= line_buf[w*32 +: 32];
    end
  end

endmodule

// File: tb/tb_m_cache_assoc.sv
// Directed bench for m_cache_assoc; expected responses are queued at issue
// time and a negedge monitor pops and compares them.
module tb_m_cache_assoc;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_req_valid;
  logic         o_req_ready;
  logic         i_req_we;
  logic [31:0]  i_req_addr;
  logic [31:0]  i_req_wdata;
  logic         o_rsp_valid;
  logic [31:0]  o_rsp_data;
  logic         o_rsp_hit;
  logic         o_mem_req_valid;
  logic         i_mem_req_ready;
  logic [31:0]  o_mem_addr;
  logic         i_mem_rsp_valid;
  logic [127:0] i_mem_rsp_data;
  logic         i_flush;
  logic         o_busy;

  int checks;
  int errors;
  logic [32:0] exp_q[$];
  logic [32:0] exp_rsp;

  m_cache_assoc dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_data     (o_rsp_data),
    .o_rsp_hit      (o_rsp_hit),
    .o_mem_req_valid(o_mem_req_valid),
    .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr     (o_mem_addr),
    .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data (i_mem_rsp_data),
    .i_flush        (i_flush),
    .o_busy         (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Response monitor: every o_rsp_valid must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (o_rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got data 0x%08h hit %0b, expected no response",
                 o_rsp_data, o_rsp_hit);
      end else begin
        exp_rsp = exp_q.pop_front();
        checkOutput("rsp_data", o_rsp_data, exp_rsp[31:0]);
        checkOutput("rsp_hit", {31'b0, o_rsp_hit}, {31'b0, exp_rsp[32]});
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_data,
                               input logic exp_hit, input logic exp_mem,
                               input logic [31:0] exp_maddr, input logic [127:0] line,
                               input int stall);
    int n;
    exp_q.push_back({exp_hit, exp_data});
    @(posedge i_clk); #1;
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    n = 0;
    @(negedge i_clk);
    while (!o_req_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_ready_timeout: got 0, expected 1 within 50 cycles");
      i_req_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(negedge i_clk);
    if (!exp_mem) begin
      checkOutput("rsp_one_cycle_after_accept", {31'b0, o_rsp_valid}, 32'd1);
      @(negedge i_clk);
      checkOutput("no_mem_req", {31'b0, o_mem_req_valid}, 32'd0);
      checkOutput("idle_after_rsp", {31'b0, o_busy}, 32'd0);
    end else begin
      checkOutput("miss_no_lookup_rsp", {31'b0, o_rsp_valid}, 32'd0);
      @(negedge i_clk);
      checkOutput("mem_req_valid", {31'b0, o_mem_req_valid}, 32'd1);
      checkOutput("mem_addr", o_mem_addr, exp_maddr);
      for (int i = 0; i < stall; i++) begin
        if (i == 0) begin
          i_mem_rsp_valid = 1'b1;
          i_mem_rsp_data  = {4{32'hBAD0BAD0}};
        end
        @(posedge i_clk); #1;
        i_mem_rsp_valid = 1'b0;
        @(negedge i_clk);
        checkOutput("stall_mem_req_valid", {31'b0, o_mem_req_valid}, 32'd1);
        checkOutput("stall_mem_addr", o_mem_addr, exp_maddr);
      end
      i_mem_req_ready = 1'b1;
      @(posedge i_clk); #1;
      i_mem_req_ready = 1'b0;
      @(negedge i_clk);
      checkOutput("wait_mem_req_dropped", {31'b0, o_mem_req_valid}, 32'd0);
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = line;
      @(posedge i_clk); #1;
      i_mem_rsp_valid = 1'b0;
      @(negedge i_clk);
      checkOutput("fill_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
    end
  endtask

  localparam logic [127:0] L1  = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] L1B = {32'h13, 32'h12, 32'h11, 32'h10};
  localparam logic [127:0] L2  = {32'h23, 32'h22, 32'h21, 32'h20};
  localparam logic [127:0] L3  = {32'h33, 32'h32, 32'h31, 32'h30};
  localparam logic [127:0] L5  = {32'h53, 32'h52, 32'h51, 32'h50};
  localparam logic [127:0] L7  = {32'h73, 32'h72, 32'h71, 32'h70};
  localparam logic [127:0] L9  = {32'h93, 32'h92, 32'h91, 32'h90};

  initial begin
    int n;
    checks          = 0;
    errors          = 0;
    i_rst_n         = 1'b0;
    i_req_valid     = 1'b0;
    i_req_we        = 1'b0;
    i_req_addr      = '0;
    i_req_wdata     = '0;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data  = '0;
    i_flush         = 1'b0;

    repeat (2) @(negedge i_clk);
    checkOutput("reset_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    checkOutput("reset_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("reset_mem_req_valid", {31'b0, o_mem_req_valid}, 32'd0);
    checkOutput("reset_mem_addr", o_mem_addr, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("ready_after_reset", {31'b0, o_req_ready}, 32'd1);

    $display("[TB] cold read, rehit, store hit/miss");
    applyStimulus(1'b0, 32'h0000_1234, 32'h0, 32'd2, 1'b0, 1'b1, 32'h0000_1230, L1, 0);
    applyStimulus(1'b0, 32'h0000_1234, 32'h0, 32'd2, 1'b1, 1'b0, 32'h0, '0, 0);
    applyStimulus(1'b1, 32'h0000_1238, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 32'h0, '0, 0);
    applyStimulus(1'b0, 32'h0000_1238, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, '0, 0);
    applyStimulus(1'b1, 32'h0000_5000, 32'h12345678, 32'h0, 1'b0, 1'b0, 32'h0, '0, 0);
    applyStimulus(1'b0, 32'h0000_5000, 32'h0, 32'h50, 1'b0, 1'b1, 32'h0000_5000, L5, 0);

    $display("[TB] replacement at index 0x23");
    applyStimulus(1'b0, 32'h0000_2230, 32'h0, 32'h20, 1'b0, 1'b1, 32'h0000_2230, L2, 0);
    applyStimulus(1'b0, 32'h0000_3230, 32'h0, 32'h30, 1'b0, 1'b1, 32'h0000_3230, L3, 0);
    applyStimulus(1'b0, 32'h0000_2230, 32'h0, 32'h20, 1'b1, 1'b0, 32'h0, '0, 0);
    applyStimulus(1'b0, 32'h0000_1230, 32'h0, 32'h10, 1'b0, 1'b1, 32'h0000_1230, L1B, 0);
    applyStimulus(1'b0, 32'h0000_3230, 32'h0, 32'h30, 1'b1, 1'b0, 32'h0, '0, 0);
    applyStimulus(1'b0, 32'h0000_2230, 32'h0, 32'h20, 1'b0, 1'b1, 32'h0000_2230, L2, 0);

    $display("[TB] flush with simultaneous request");
    @(posedge i_clk); #1;
    i_flush     = 1'b1;
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 32'h0000_1230;
    @(negedge i_clk);
    checkOutput("ready_low_during_flush_req", {31'b0, o_req_ready}, 32'd0);
    @(posedge i_clk); #1;
    i_flush     = 1'b0;
    i_req_valid = 1'b0;
    n = 0;
    @(negedge i_clk);
    while (o_busy && n < 1000) begin
      n++;
      @(negedge i_clk);
    end
    checkOutput("flush_busy_cycles", n, 32'd256);
    applyStimulus(1'b0, 32'h0000_1230, 32'h0, 32'h10, 1'b0, 1'b1, 32'h0000_1230, L1B, 0);
    applyStimulus(1'b0, 32'h0000_5000, 32'h0, 32'h50, 1'b0, 1'b1, 32'h0000_5000, L5, 0);
    applyStimulus(1'b0, 32'h0000_2230, 32'h0, 32'h20, 1'b0, 1'b1, 32'h0000_2230, L2, 0);

    $display("[TB] memory backpressure");
    applyStimulus(1'b0, 32'h0000_7048, 32'h0, 32'h72, 1'b0, 1'b1, 32'h0000_7040, L7, 5);

    $display("[TB] reset during MISS_WAIT");
    @(posedge i_clk); #1;
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 32'h0000_9000;
    @(negedge i_clk);
    checkOutput("ready_before_abort", {31'b0, o_req_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("abort_mem_req_valid", {31'b0, o_mem_req_valid}, 32'd1);
    i_mem_req_ready = 1'b1;
    @(posedge i_clk); #1;
    i_mem_req_ready = 1'b0;
    @(negedge i_clk);
    checkOutput("abort_in_miss_wait", {31'b0, o_busy}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("abort_busy_cleared", {31'b0, o_busy}, 32'd0);
    checkOutput("abort_mem_addr_cleared", o_mem_addr, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("ready_after_abort", {31'b0, o_req_ready}, 32'd1);
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_data  = L9;
    @(posedge i_clk); #1;
    i_mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checkOutput("late_rsp_ignored", {31'b0, o_rsp_valid}, 32'd0);
      checkOutput("late_rsp_idle", {31'b0, o_busy}, 32'd0);
    end
    applyStimulus(1'b0, 32'h0000_9000, 32'h0, 32'h90, 1'b0, 1'b1, 32'h0000_9000, L9, 0);

    repeat (3) @(negedge i_clk);
    checkOutput("pending_responses", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
